// File: rtl/seg_frame_capture_if.sv
// Display bus (segments/anodes in) and recovered frame (out) between a driver and the capture monitor.
// Optional frame_dp signal present when SEG_CAPTURE_DP_EN is defined.
interface seg_frame_capture_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [7:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [5*NUM_DIGITS-1:0] frame_code;
    logic                    frame_valid;
    logic                    frame_err;
    logic                    an_err;
`ifdef SEG_CAPTURE_DP_EN
    logic [NUM_DIGITS-1:0]   frame_dp;

    modport master (
        output seg_in, an_in,
        input  frame_code, frame_valid, frame_err, an_err, frame_dp
    );
    modport slave (
        input  seg_in, an_in,
        output frame_code, frame_valid, frame_err, an_err, frame_dp
    );
`else
    modport master (
        output seg_in, an_in,
        input  frame_code, frame_valid, frame_err, an_err
    );
    modport slave (
        input  seg_in, an_in,
        output frame_code, frame_valid, frame_err, an_err
    );
`endif
endinterface

// File: rtl/seg_frame_capture.sv
// Recovers per-digit symbol codes from a multiplexed active-low seg/anode bus, one code word per scan.
// SEG_CAPTURE_DP_EN: decode on seg[6:0] only and report each digit's decimal point on frame_dp.
module seg_frame_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    seg_frame_capture_if.slave bus
);
    localparam int unsigned CODE_W = 5;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned FRM_W  = CODE_W * NUM_DIGITS;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc_c;
    logic [7:0]              seg_q, seg_d1_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d1_q;
    logic [NUM_DIGITS-1:0]   an_low_c;
    logic                    one_hot_c, multi_low_c, changed_c, enter_c;
    logic [IDX_W-1:0]        idx_c;
    logic [7:0]              dec_seg_c;
    logic [CODE_W-1:0]       code_c;
    logic                    capture_c, an_err_c, frame_done_c;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d, err_q, err_d;
    logic [CODE_W-1:0]       slot_q [NUM_DIGITS];
    logic [FRM_W-1:0]        frame_code_q, frame_code_d;
    logic                    frame_valid_q, frame_err_q, an_err_q;
`ifdef SEG_CAPTURE_DP_EN
    logic [NUM_DIGITS-1:0]   dp_q, frame_dp_q;
`endif

    // Segment pattern to symbol code; shared patterns resolve to the lowest code.
    function automatic logic [CODE_W-1:0] decode_seg(input logic [7:0] s);
        case (s)
            8'hc0:   decode_seg = 5'h00;
            8'hf9:   decode_seg = 5'h01;
            8'ha4:   decode_seg = 5'h02;
            8'hb0:   decode_seg = 5'h03;
            8'h99:   decode_seg = 5'h04;
            8'h92:   decode_seg = 5'h05;
            8'h82:   decode_seg = 5'h06;
            8'hf8:   decode_seg = 5'h07;
            8'h80:   decode_seg = 5'h08;
            8'h90:   decode_seg = 5'h09;
            8'h7f:   decode_seg = 5'h0A;
            8'h83:   decode_seg = 5'h0B;
            8'hc6:   decode_seg = 5'h0C;
            8'ha1:   decode_seg = 5'h0D;
            8'h86:   decode_seg = 5'h0E;
            8'hff:   decode_seg = 5'h0F;
            8'h8f:   decode_seg = 5'h11;
            8'h0f:   decode_seg = 5'h12;
            8'h87:   decode_seg = 5'h13;
            8'ha3:   decode_seg = 5'h14;
            8'he3:   decode_seg = 5'h15;
            8'h89:   decode_seg = 5'h16;
            default: decode_seg = 5'h1F;
        endcase
    endfunction

    // Input register plus one-cycle history for change detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q    <= '1;
            seg_d1_q <= '1;
            an_q     <= '1;
            an_d1_q  <= '1;
        end else begin
            seg_q    <= bus.seg_in;
            seg_d1_q <= seg_q;
            an_q     <= bus.an_in;
            an_d1_q  <= an_q;
        end
    end

    // Anode classification, lit digit index and code of the current pattern.
    always_comb begin
        an_low_c    = ~an_q;
        one_hot_c   = (an_low_c != '0) &&
                      ((an_low_c & (an_low_c - NUM_DIGITS'(1))) == '0);
        multi_low_c = (an_low_c != '0) && !one_hot_c;
        changed_c   = (seg_q != seg_d1_q) || (an_q != an_d1_q);
        idx_c       = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (an_low_c[i]) idx_c = IDX_W'(i);
        end
`ifdef SEG_CAPTURE_DP_EN
        dec_seg_c = {1'b1, seg_q[6:0]};
`else
        dec_seg_c = seg_q;
`endif
        code_c = decode_seg(dec_seg_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Settle FSM: a digit is sampled once after SETTLE_CYCLES unchanged cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_inc_c = cnt_q + CNT_W'(1);
        enter_c   = 1'b0;
        capture_c = 1'b0;
        an_err_c  = 1'b0;
        case (state_q)
            ST_WAIT:   enter_c = 1'b1;
            ST_SETTLE: begin
                if (changed_c) begin
                    enter_c = 1'b1;
                end else if (cnt_inc_c == CNT_W'(SETTLE_CYCLES)) begin
                    capture_c = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_HOLD;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            ST_HOLD:   enter_c = changed_c;
            default:   state_d = ST_WAIT;
        endcase
        if (enter_c) begin
            cnt_d   = '0;
            state_d = ST_WAIT;
            if (multi_low_c) begin
                an_err_c = 1'b1;
            end else if (one_hot_c) begin
                if (SETTLE_CYCLES <= 1) begin
                    capture_c = 1'b1;
                    state_d   = ST_HOLD;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_SETTLE;
                end
            end
        end
    end

    // Slot bookkeeping; a capture landing on the frame-complete cycle starts the next frame.
    always_comb begin
        frame_done_c = &mask_q;
        mask_d       = frame_done_c ? '0 : mask_q;
        err_d        = frame_done_c ? '0 : err_q;
        if (capture_c) begin
            mask_d[idx_c] = 1'b1;
            err_d[idx_c]  = (code_c == 5'h1F);
        end
        frame_code_d = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            frame_code_d[CODE_W*i +: CODE_W] = slot_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q        <= '0;
            err_q         <= '0;
            frame_code_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            an_err_q      <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) slot_q[i] <= '0;
`ifdef SEG_CAPTURE_DP_EN
            dp_q          <= '0;
            frame_dp_q    <= '0;
`endif
        end else begin
            mask_q        <= mask_d;
            err_q         <= err_d;
            an_err_q      <= an_err_c;
            frame_valid_q <= frame_done_c;
            frame_err_q   <= frame_done_c && (|err_q);
            if (frame_done_c) begin
                frame_code_q <= frame_code_d;
`ifdef SEG_CAPTURE_DP_EN
                frame_dp_q   <= dp_q;
`endif
            end
            if (capture_c) begin
                slot_q[idx_c] <= code_c;
`ifdef SEG_CAPTURE_DP_EN
                dp_q[idx_c]   <= ~seg_q[7];
`endif
            end
        end
    end

    assign bus.frame_code  = frame_code_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.an_err      = an_err_q;
`ifdef SEG_CAPTURE_DP_EN
    assign bus.frame_dp    = frame_dp_q;
`endif

endmodule

// File: tb/tb_seg_frame_capture.sv
// Directed bench for seg_frame_capture: scans, decode table, an_err, settle filtering, reset, dp option.
module tb_seg_frame_capture;
    localparam int unsigned ND = 4;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned fv_cnt = 0;
    int unsigned ae_cnt = 0;
    int unsigned fv0, ae0;
    int          lat;
    logic [19:0] last_code = '0;
    logic        last_err  = 1'b0;
    logic [3:0]  last_dp   = '0;

    seg_frame_capture_if #(.NUM_DIGITS(ND)) bus ();

    seg_frame_capture #(.NUM_DIGITS(ND), .SETTLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Record frame pulses and an_err pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.frame_valid) begin
            fv_cnt++;
            last_code = bus.frame_code;
            last_err  = bus.frame_err;
`ifdef SEG_CAPTURE_DP_EN
            last_dp   = bus.frame_dp;
`endif
        end
        if (bus.an_err) ae_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [3:0] an, input logic [7:0] seg, input int n);
        bus.an_in  = an;
        bus.seg_in = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3);
        show(4'he, s0, 8);
        show(4'hd, s1, 8);
        show(4'hb, s2, 8);
        show(4'h7, s3, 8);
        show(4'hf, 8'hff, 4);
    endtask

    task automatic frame_check(input string tag, input int unsigned fv_before,
                               input logic [19:0] code, input logic err);
        check({tag, "_count"}, fv_cnt - fv_before, 1);
        check({tag, "_code"}, 32'(last_code), 32'(code));
        check({tag, "_err"}, 32'(last_err), 32'(err));
    endtask

    initial begin
        reset      = 1'b1;
        bus.an_in  = 4'hf;
        bus.seg_in = 8'hff;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_code", 32'(bus.frame_code), 0);
        check("rst_valid", 32'(bus.frame_valid), 0);
        check("rst_err", 32'(bus.frame_err), 0);
        check("rst_an_err", 32'(bus.an_err), 0);
        @(posedge clk); #1;
        show(4'hf, 8'hff, 2);

        // Basic scan plus latency of the last digit.
        fv0 = fv_cnt;
        show(4'he, 8'hc0, 8);
        show(4'hd, 8'hf9, 8);
        show(4'hb, 8'ha4, 8);
        bus.an_in  = 4'h7;
        bus.seg_in = 8'hb0;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.frame_valid && lat < 0) lat = k;
        end
        @(posedge clk); #1;
        show(4'hf, 8'hff, 4);
        check("t1_latency", 32'(lat), 6);
        frame_check("t1", fv0, 20'h18820, 1'b0);

        // Shared patterns and an unknown pattern.
        fv0 = fv_cnt;
        scan(8'hc0, 8'hab, 8'h86, 8'ha1);
        frame_check("t2", fv0, 20'h6BBE0, 1'b1);

        // Two anodes low for one cycle mid-frame.
        fv0 = fv_cnt;
        ae0 = ae_cnt;
        show(4'he, 8'hc0, 8);
        show(4'hd, 8'hf9, 8);
        show(4'hc, 8'hff, 1);
        show(4'hb, 8'ha4, 8);
        show(4'h7, 8'hb0, 8);
        show(4'hf, 8'hff, 4);
        check("t3_an_err", ae_cnt - ae0, 1);
        frame_check("t3", fv0, 20'h18820, 1'b0);

        // Dwells too short to settle, and a glitch restarting the settle count.
        fv0 = fv_cnt;
        for (int k = 0; k < 4; k++) begin
            show(4'he, 8'hc0, 3);
            show(4'hd, 8'hf9, 3);
        end
        show(4'hb, 8'ha4, 3);
        show(4'hb, 8'hff, 1);
        show(4'hb, 8'ha4, 3);
        show(4'h7, 8'hb0, 8);
        show(4'hf, 8'hff, 6);
        check("t4_no_frame", fv_cnt - fv0, 0);
        show(4'he, 8'hc0, 8);
        show(4'hd, 8'hf9, 8);
        show(4'hb, 8'ha4, 8);
        show(4'hf, 8'hff, 4);
        frame_check("t4", fv0, 20'h18820, 1'b0);

        // Reset after two captured digits discards them.
        fv0 = fv_cnt;
        show(4'he, 8'hf9, 8);
        show(4'hd, 8'ha4, 8);
        reset = 1'b1;
        show(4'hf, 8'hff, 2);
        reset = 1'b0;
        @(negedge clk);
        check("t5_rst_code", 32'(bus.frame_code), 0);
        check("t5_rst_valid", 32'(bus.frame_valid), 0);
        @(posedge clk); #1;
        show(4'hb, 8'hb0, 8);
        show(4'h7, 8'h99, 8);
        show(4'hf, 8'hff, 4);
        check("t5_partial", fv_cnt - fv0, 0);
        show(4'he, 8'hf9, 8);
        show(4'hd, 8'ha4, 8);
        show(4'hf, 8'hff, 4);
        frame_check("t5", fv0, 20'h20C41, 1'b0);

        // Patterns whose meaning depends on the dp option.
        fv0 = fv_cnt;
        scan(8'h0f, 8'h7f, 8'h40, 8'h8f);
`ifdef SEG_CAPTURE_DP_EN
        frame_check("t6", fv0, 20'h881F1, 1'b0);
        check("t6_dp", 32'(last_dp), 32'h7);
`else
        frame_check("t6", fv0, 20'h8FD52, 1'b1);
`endif

        // Remaining table entries; digit 0 re-sampled, latest value wins.
        fv0 = fv_cnt;
        show(4'he, 8'hc0, 8);
        show(4'hf, 8'hff, 2);
        scan(8'h82, 8'hf8, 8'h80, 8'h90);
        frame_check("t7a", fv0, 20'h4A0E6, 1'b0);
        fv0 = fv_cnt;
        scan(8'h83, 8'hc6, 8'h87, 8'h89);
        frame_check("t7b", fv0, 20'hB4D8B, 1'b0);
        fv0 = fv_cnt;
        scan(8'ha3, 8'he3, 8'h92, 8'hff);
        frame_check("t7c", fv0, 20'h796B4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
